// File: rtl/time_set_uart_rx.sv
// time_set_uart_rx: 8N1 UART receiver that parses "T" HHMMSS <CR> frames into BCD digits with a load strobe.
// Optional inter-byte timeout enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115_200
`ifdef TIME_SET_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 50_000_000
`endif
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_rx,
  output logic       o_load,
  output logic [3:0] o_hour1,
  output logic [3:0] o_hour0,
  output logic [3:0] o_min1,
  output logic [3:0] o_min0,
  output logic [3:0] o_sec1,
  output logic [3:0] o_sec0,
  output logic       o_frame_err,
  output logic       o_fmt_err
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam logic [15:0] BIT_END = 16'(CPB - 1);
  localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} r_state_e;
  typedef enum logic [2:0] {P_IDLE, P_D0, P_D1, P_D2, P_D3, P_D4, P_D5, P_CR} p_state_e;
  logic rx_m, rx_s, rx_d;
  r_state_e r_st, r_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [7:0] shr, shr_nxt;
  logic byte_vld, vld_nxt, frame_err, ferr_nxt;
  p_state_e p_st, p_nxt;
  logic [3:0] sh [6];
  logic [2:0] idx;
  logic [7:0] dig;
  logic [3:0] lim;
  logic dig_ok, sh_we, sh_clr, ld, fe, to_hit;
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      {rx_m, rx_s, rx_d} <= 3'b111;
      r_st <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shr <= '0;
      byte_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_d} <= {i_rx, rx_m, rx_s};
      r_st <= r_nxt;
      cnt <= cnt_nxt;
      bit_idx <= bit_nxt;
      shr <= shr_nxt;
      byte_vld <= vld_nxt;
      frame_err <= ferr_nxt;
    end
  end
  always_comb begin
    r_nxt = r_st;
    cnt_nxt = cnt + 16'd1;
    bit_nxt = bit_idx;
    shr_nxt = shr;
    vld_nxt = 1'b0;
    ferr_nxt = 1'b0;
    case (r_st)
      R_IDLE: begin
        cnt_nxt = '0;
        r_nxt = (rx_d & ~rx_s) ? R_START : R_IDLE;
      end
      R_START: if (cnt == HALF_END) begin
        cnt_nxt = '0;
        bit_nxt = '0;
        r_nxt = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == BIT_END) begin
        cnt_nxt = '0;
        shr_nxt = {rx_s, shr[7:1]};
        bit_nxt = bit_idx + 3'd1;
        r_nxt = (bit_idx == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt == BIT_END) begin
        cnt_nxt = '0;
        vld_nxt = rx_s;
        ferr_nxt = ~rx_s;
        r_nxt = rx_s ? R_IDLE : R_BREAK;
      end
      default: begin
        cnt_nxt = '0;
        r_nxt = rx_s ? R_IDLE : R_BREAK;
      end
    endcase
  end
  assign o_frame_err = frame_err;
  assign idx = 3'(p_st) - 3'd1;
  assign dig = shr - 8'h30;
  assign lim = (p_st == P_D0) ? 4'd2 :
               (p_st == P_D1) ? ((sh[0] == 4'd2) ? 4'd3 : 4'd9) :
               (p_st == P_D2 || p_st == P_D4) ? 4'd5 : 4'd9;
  assign dig_ok = (shr >= 8'h30) && (dig <= {4'd0, lim});
`ifdef TIME_SET_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge i_clk) begin
    if (i_srst || byte_vld || p_st == P_IDLE) to_cnt <= '0;
    else to_cnt <= to_cnt + 32'd1;
  end
  assign to_hit = (p_st != P_IDLE) && (to_cnt == 32'(TIMEOUT_CLKS - 1));
`else
  assign to_hit = 1'b0;
`endif
  // 'T' restarts from any state; a received byte takes priority over a coincident timeout
  always_comb begin
    p_nxt = p_st;
    sh_we = 1'b0;
    sh_clr = 1'b0;
    ld = 1'b0;
    fe = 1'b0;
    if (frame_err) p_nxt = P_IDLE;
    else if (byte_vld) begin
      if (shr == 8'h54) begin
        sh_clr = 1'b1;
        p_nxt = P_D0;
      end else if (p_st == P_CR) begin
        ld = (shr == 8'h0d);
        fe = ~ld;
        p_nxt = P_IDLE;
      end else if (p_st != P_IDLE) begin
        sh_we = dig_ok;
        fe = ~dig_ok;
        p_nxt = dig_ok ? p_state_e'(p_st + 3'd1) : P_IDLE;
      end
    end else if (to_hit) begin
      fe = 1'b1;
      p_nxt = P_IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      p_st <= P_IDLE;
      sh <= '{default: 4'd0};
      o_load <= 1'b0;
      o_fmt_err <= 1'b0;
      {o_hour1, o_hour0, o_min1, o_min0, o_sec1, o_sec0} <= '0;
    end else begin
      p_st <= p_nxt;
      o_load <= ld;
      o_fmt_err <= fe;
      if (sh_clr) sh <= '{default: 4'd0};
      else if (sh_we) sh[idx] <= dig[3:0];
      if (ld) {o_hour1, o_hour0, o_min1, o_min0, o_sec1, o_sec0} <= {sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]};
    end
  end
endmodule

// File: tb/tb_time_set_uart_rx.sv
// tb_time_set_uart_rx: directed frames against a scoreboard of expected load/error events and digit values.
module tb_time_set_uart_rx;
  localparam logic [2:0] K_LOAD = 3'b100, K_FRM = 3'b010, K_FMT = 3'b001;
  typedef struct packed {logic [2:0] kind; logic [23:0] dig;} ev_t;
  logic clk = 1'b0, srst = 1'b1, rx = 1'b1;
  logic load, frame_err, fmt_err;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [23:0] digs, cur = '0;
  int n_assert = 0, n_fail = 0;
  ev_t sb[$];
  always #5 clk = ~clk;
  assign digs = {h1, h0, m1, m0, s1, s0};
  time_set_uart_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD(100_000)
`ifdef TIME_SET_TIMEOUT_EN
    , .TIMEOUT_CLKS(1000)
`endif
  ) dut (
    .i_clk(clk), .i_srst(srst), .i_rx(rx), .o_load(load),
    .o_hour1(h1), .o_hour0(h0), .o_min1(m1), .o_min0(m0), .o_sec1(s1), .o_sec0(s0),
    .o_frame_err(frame_err), .o_fmt_err(fmt_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (load | frame_err | fmt_err) begin
      chk("event_expected", 32'(sb.size() != 0), 32'd1);
      e = '0;
      if (sb.size() != 0) e = sb.pop_front();
      chk("event_kind", 32'({load, frame_err, fmt_err}), 32'(e.kind));
      chk("event_digits", 32'(digs), 32'(e.dig));
    end
  endtask
  task automatic push(input logic [2:0] kind, input logic [23:0] d);
    if (kind == K_LOAD) cur = d;
    sb.push_back('{kind: kind, dig: (kind == K_LOAD) ? d : cur});
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) tick();
    end
    rx = stop;
    repeat (10) tick();
    rx = 1'b1;
    repeat (3) tick();
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask
  task automatic frame(input string s);
    send_str(s);
    send_byte(8'h0d, 1'b1);
  endtask
  task automatic drain(input string tag);
    repeat (30) tick();
    chk({tag, "_pending"}, 32'(sb.size()), 32'd0);
    chk({tag, "_digits"}, 32'(digs), 32'(cur));
  endtask
  initial begin
    repeat (3) tick();
    srst = 1'b0;
    chk("reset_outputs", 32'({load, frame_err, fmt_err, digs}), 32'd0);
    push(K_LOAD, 24'h123456);
    frame("T123456");
    drain("basic");
    push(K_FMT, 24'h0);
    frame("T245959");
    drain("hour_units_range");
    push(K_LOAD, 24'h235959);
    frame("T12T235959");
    drain("restart_max");
    push(K_FRM, 24'h0);
    send_byte(8'h54, 1'b0);
    push(K_LOAD, 24'h000000);
    frame("T000000");
    drain("frame_err_recover");
    send_str("T1200");
    srst = 1'b1;
    tick();
    srst = 1'b0;
    cur = '0;
    send_str("00");
    send_byte(8'h0d, 1'b1);
    drain("reset_midframe");
    push(K_LOAD, 24'h195959);
    frame("xyT195959");
    drain("hour19_junk_prefix");
    push(K_FMT, 24'h0);
    frame("T196000");
    drain("min_tens_range");
    push(K_FMT, 24'h0);
    send_str("T1234567");
    drain("missing_cr");
    push(K_FMT, 24'h0);
    frame("T0A");
    drain("non_digit");
    push(K_FMT, 24'h0);
    frame("T30");
    drain("hour_tens_range");
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    drain("start_glitch");
`ifdef TIME_SET_TIMEOUT_EN
    push(K_FMT, 24'h0);
    send_str("T12");
    repeat (1100) tick();
    drain("timeout");
    push(K_LOAD, 24'h010203);
    frame("T010203");
    drain("after_timeout");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
